// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache. Misses are filled
// with four sequential byte reads assembled little-endian.
module icache #(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned ADD_W = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        iIF_En,
  input  logic [31:0] iIF_Add,
  input  logic        iClr,
  output logic        oIF_En,
  output logic [31:0] oIF_Ins,
  output logic        oMC_En,
  output logic [31:0] oMC_Add,
  input  logic        iMC_En,
  input  logic [7:0]  iMC_Dat
);

  localparam int unsigned LINES = 2 ** IDX_W;
  localparam int unsigned TAG_W = ADD_W - IDX_W - 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         k_q, k_d;
  logic [29:0]        pc_q, pc_d;
  logic [23:0]        word_q, word_d;
  logic               if_en_q, if_en_d;
  logic [31:0]        if_ins_q, if_ins_d;
  logic               mc_en_q, mc_en_d;
  logic [31:0]        mc_add_q, mc_add_d;
  logic [LINES-1:0]   valid_q, valid_d;

  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [31:0]        data_q [LINES];

  logic [IDX_W-1:0]   lookup_idx;
  logic [TAG_W-1:0]   lookup_tag;
  logic               hit;
  logic [IDX_W-1:0]   fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic [31:0]        fill_data;
  logic               fill_we;
  logic [1:0]         k_inc;
  logic [1:0]         unused_addr;

  assign unused_addr = iIF_Add[1:0];

  // Hit check against the incoming PC so a hit answers on the next edge
  assign lookup_idx = iIF_Add[IDX_W+1:2];
  assign lookup_tag = iIF_Add[ADD_W-1:IDX_W+2];
  assign hit        = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);

  assign fill_idx  = pc_q[IDX_W-1:0];
  assign fill_tag  = pc_q[ADD_W-3:IDX_W];
  assign fill_data = {iMC_Dat, word_q};
  assign k_inc     = k_q + 2'd1;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    pc_d     = pc_q;
    word_d   = word_q;
    if_en_d  = 1'b0;
    if_ins_d = if_ins_q;
    mc_en_d  = 1'b0;
    mc_add_d = mc_add_q;
    valid_d  = valid_q;
    fill_we  = 1'b0;

    if (en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (iIF_En && !iClr) begin
            pc_d = iIF_Add[31:2];
            if (hit) begin
              if_en_d  = 1'b1;
              if_ins_d = data_q[lookup_idx];
            end else begin
              mc_en_d  = 1'b1;
              mc_add_d = {iIF_Add[31:2], 2'b00};
              k_d      = 2'd0;
              state_d  = ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          // A flush with a byte in hand has nothing left outstanding
          if (iClr) begin
            state_d = iMC_En ? ST_IDLE : ST_DRAIN;
            k_d     = 2'd0;
          end else if (iMC_En) begin
            if (k_q == 2'd3) begin
              fill_we            = 1'b1;
              valid_d[fill_idx]  = 1'b1;
              if_en_d            = 1'b1;
              if_ins_d           = fill_data;
              k_d                = 2'd0;
              state_d            = ST_IDLE;
            end else begin
              unique case (k_q)
                2'd0:    word_d[7:0]   = iMC_Dat;
                2'd1:    word_d[15:8]  = iMC_Dat;
                default: word_d[23:16] = iMC_Dat;
              endcase
              k_d      = k_inc;
              mc_en_d  = 1'b1;
              mc_add_d = {pc_q, k_inc};
            end
          end
        end

        ST_DRAIN: begin
          if (iMC_En) begin
            state_d = ST_IDLE;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      k_q      <= 2'd0;
      pc_q     <= 30'd0;
      word_q   <= 24'd0;
      if_en_q  <= 1'b0;
      if_ins_q <= 32'd0;
      mc_en_q  <= 1'b0;
      mc_add_q <= 32'd0;
      valid_q  <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      pc_q     <= pc_d;
      word_q   <= word_d;
      if_en_q  <= if_en_d;
      if_ins_q <= if_ins_d;
      mc_en_q  <= mc_en_d;
      mc_add_q <= mc_add_d;
      valid_q  <= valid_d;
    end
  end

  // Tag and data arrays carry no reset; valid bits guard them
  always_ff @(posedge clk) begin
    if (rst_n && fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= fill_data;
    end
  end

  assign oIF_En  = if_en_q;
  assign oIF_Ins = if_ins_q;
  assign oMC_En  = mc_en_q;
  assign oMC_Add = mc_add_q;

endmodule
